gcd_bcd_convert: RTL

//   Downstream of the GCD control FSM/datapath: captures the GCD result on the

---
 rtl/gcd_bcd_convert_if.sv | 15 +
 rtl/gcd_bcd_convert.sv | 112 +++++++++++
 2 files changed

// File: rtl/gcd_bcd_convert_if.sv
// Handshake bundle between the GCD controller side and the BCD converter.
// master drives the result strobe, slave returns the display value and status.
interface gcd_bcd_convert_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  done;
    logic [WIDTH-1:0]      gcd_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  bcd_valid;
    logic                  busy;

    modport master (output done, gcd_in, input bcd_out, bcd_valid, busy);
    modport slave  (input done, gcd_in, output bcd_out, bcd_valid, busy);
endinterface

// File: rtl/gcd_bcd_convert.sv
// Captures the GCD result on done and converts it to packed BCD with a serial
// shift-add-3 engine, one bit per cycle; the last result is held for display.
module gcd_bcd_convert #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    gcd_bcd_convert_if.slave    bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    if (10 ** DIGITS < 2 ** WIDTH) begin : g_chk
        $error("gcd_bcd_convert: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] bin_sr, bin_n;
    logic [BW-1:0]    bcd_sr, bcd_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             pend_vld, pend_vld_n;
    logic [WIDTH-1:0] pend_val, pend_val_n;
    logic [BW-1:0]    out_q, out_n;
    logic             valid_q, valid_n;
    logic [BW-1:0]    bcd_adj;

    // Per-digit +3 correction; digits never exceed 9 so the add stays in 4 bits
    always_comb begin
        bcd_adj = bcd_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n    = state;
        bin_n      = bin_sr;
        bcd_n      = bcd_sr;
        cnt_n      = cnt;
        pend_vld_n = pend_vld;
        pend_val_n = pend_val;
        out_n      = out_q;
        valid_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.done) begin
                    bin_n   = bus.gcd_in;
                    bcd_n   = '0;
                    cnt_n   = CW'(WIDTH);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                bcd_n = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
                bin_n = bin_sr << 1;
                cnt_n = cnt - 1'b1;
                // A result arriving mid-conversion is queued; latest one wins
                if (bus.done) begin
                    pend_vld_n = 1'b1;
                    pend_val_n = bus.gcd_in;
                end
                if (cnt == CW'(1)) begin
                    out_n   = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
                    valid_n = 1'b1;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                if (bus.done || pend_vld) begin
                    bin_n      = bus.done ? bus.gcd_in : pend_val;
                    bcd_n      = '0;
                    cnt_n      = CW'(WIDTH);
                    pend_vld_n = 1'b0;
                    state_n    = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            bin_sr   <= bin_n;
            bcd_sr   <= bcd_n;
            cnt      <= cnt_n;
            pend_vld <= pend_vld_n;
            pend_val <= pend_val_n;
            out_q    <= out_n;
            valid_q  <= valid_n;
        end
    end

    assign bus.bcd_out   = out_q;
    assign bus.bcd_valid = valid_q;
    assign bus.busy      = (state != IDLE);
endmodule
